rtp_ray_dispatch: RTL and testbench

Frame-level scheduler for the ray-traversal pipeline. Starts a frame on command, hands ray IDs `0..N-1` to two traversal lanes with round-robin sharing and an in-flight credit limit, and counts per-lane completions. Raises `io_rtp_finish` when every ray has retired, and reports the cycle count of the frame. Sits between the host/testbench control and the two traversal lanes, one per stack manager.

---
 rtl/rtp_ctrl_pkg.sv | 21 ++
 rtl/rr_arb2.sv | 52 +++++
 rtl/rtp_ray_dispatch.sv | 166 ++++++++++++++++
 tb/tb_rtp_ray_dispatch.sv | 358 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rtp_ctrl_pkg.sv
// rtp_ctrl_pkg
//   Shared definitions for the ray-dispatch control slice: the dispatcher FSM
//   state encoding, the number of traversal lanes, the cycle-counter width
//   and a small popcount helper for the per-lane completion pulses.
package rtp_ctrl_pkg;

    localparam int RTP_LANES = 2;
    localparam int RTP_CYC_W = 64;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } dispatch_state_t;

    // Number of lanes reporting a completion this cycle (0, 1 or 2).
    function automatic logic [1:0] popcount2(input logic [RTP_LANES-1:0] v);
        return {1'b0, v[0]} + {1'b0, v[1]};
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// rr_arb2
//   Two-requester round-robin arbiter. The grant is combinational from the
//   request vector and the last-granted lane; the last-granted lane only
//   moves when the caller reports that the grant was actually used.
//
//   Ports:
//     clock      in  1  rising-edge clock
//     reset_n    in  1  asynchronous active-low reset
//     req        in  2  per-lane request
//     advance    in  1  grant consumed this cycle; record it as last
//     grant_idx  out 1  granted lane (0 when nothing requests)
//     any        out 1  at least one lane requests
module rr_arb2
    import rtp_ctrl_pkg::*;
(
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic [RTP_LANES-1:0] req,
    input  logic                 advance,
    output logic                 grant_idx,
    output logic                 any
);

    logic rr_last_q;
    logic rr_last_d;

    always_comb begin
        any       = |req;
        grant_idx = 1'b0;
        case (req)
            2'b10:   grant_idx = 1'b1;
            // Tie: the lane that did not win last time gets it.
            2'b11:   grant_idx = ~rr_last_q;
            default: grant_idx = 1'b0;
        endcase

        rr_last_d = rr_last_q;
        if (advance && any) begin
            rr_last_d = grant_idx;
        end
    end

    // Resetting to lane 1 makes lane 0 win the very first tie.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rr_last_q <= 1'b1;
        end else begin
            rr_last_q <= rr_last_d;
        end
    end

endmodule

// File: rtl/rtp_ray_dispatch.sv
// rtp_ray_dispatch
//   Frame-level scheduler for the ray-traversal pipeline. A start pulse
//   latches the ray count and enters RUN; ray IDs 0..N-1 are handed to two
//   traversal lanes (round-robin on ready) under an in-flight credit limit.
//   Per-lane completions are counted; once every ray has retired the block
//   sits in DONE with io_rtp_finish high until the next start.
//
//   Ports:
//     clock             in  1          rising-edge clock
//     reset_n           in  1          asynchronous active-low reset
//     io_start          in  1          frame start pulse (ignored in RUN)
//     io_num_rays       in  ID_W       ray count, latched on accepted start
//     io_issue_valid    out 1          a ray ID is offered
//     io_issue_ray_id   out ID_W       offered ray ID
//     io_issue_ready    in  2          per-lane ready
//     io_issue_lane     out 1          lane granted (0 while not valid)
//     io_done_valid     in  2          per-lane completion pulse
//     io_busy           out 1          state is RUN
//     io_rtp_finish     out 1          state is DONE
//     io_inflight       out IF_W       rays issued and not yet completed
//     io_counter_cycles out 64         RUN cycles of current / last frame
//     io_err            out 1          sticky completion-underflow flag
//     io_dbg_state      out 2          FSM state, for debug and checkers
module rtp_ray_dispatch
    import rtp_ctrl_pkg::*;
#(
    parameter  int MAX_INFLIGHT = 16,
    parameter  int ID_W         = 32,
    localparam int IF_W         = $clog2(MAX_INFLIGHT + 1)
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic                 io_start,
    input  logic [ID_W-1:0]      io_num_rays,
    output logic                 io_issue_valid,
    output logic [ID_W-1:0]      io_issue_ray_id,
    input  logic [RTP_LANES-1:0] io_issue_ready,
    output logic                 io_issue_lane,
    input  logic [RTP_LANES-1:0] io_done_valid,
    output logic                 io_busy,
    output logic                 io_rtp_finish,
    output logic [IF_W-1:0]      io_inflight,
    output logic [RTP_CYC_W-1:0] io_counter_cycles,
    output logic                 io_err,
    output logic [1:0]           io_dbg_state
);

    localparam int              AW     = IF_W + 1;
    localparam int              DW     = ID_W + 1;
    localparam logic [IF_W-1:0] MAX_IF = IF_W'(MAX_INFLIGHT);

    dispatch_state_t      state_q, state_d;
    logic [ID_W-1:0]      num_rays_q, num_rays_d;
    logic [ID_W-1:0]      next_id_q, next_id_d;
    // One bit wider than the ray count: two completions in the last cycle
    // may carry the total one past num_rays.
    logic [DW-1:0]        done_cnt_q, done_cnt_d;
    logic [IF_W-1:0]      inflight_q, inflight_d;
    logic [RTP_CYC_W-1:0] cycles_q, cycles_d;
    logic                 err_q, err_d;

    logic                 issue_valid;
    logic                 any_ready;
    logic                 grant;
    logic                 fire;
    logic [1:0]           n_done;
    logic [AW-1:0]        avail;
    logic [DW-1:0]        done_sum;

    // Issue handshake: valid/ray_id are offered purely from internal state
    // (never from ready); the ID is consumed at the rising edge where valid
    // and at least one lane's ready are both high, going to io_issue_lane.
    // The next ID is offered from the following cycle.
    assign issue_valid = (state_q == RUN) && (next_id_q < num_rays_q) &&
                         (inflight_q < MAX_IF);
    assign fire        = issue_valid & any_ready;
    assign n_done      = popcount2(io_done_valid);

    rr_arb2 u_arb (
        .clock     (clock),
        .reset_n   (reset_n),
        .req       (io_issue_ready),
        .advance   (fire),
        .grant_idx (grant),
        .any       (any_ready)
    );

    always_comb begin
        state_d    = state_q;
        num_rays_d = num_rays_q;
        next_id_d  = next_id_q;
        done_cnt_d = done_cnt_q;
        inflight_d = inflight_q;
        cycles_d   = cycles_q;
        err_d      = err_q;
        avail      = AW'(inflight_q) + AW'(fire);
        done_sum   = done_cnt_q + DW'(n_done);

        unique case (state_q)
            IDLE, DONE: begin
                if (io_start) begin
                    state_d    = RUN;
                    num_rays_d = io_num_rays;
                    next_id_d  = '0;
                    done_cnt_d = '0;
                    inflight_d = '0;
                    cycles_d   = '0;
                    err_d      = 1'b0;
                end
            end
            RUN: begin
                cycles_d = cycles_q + RTP_CYC_W'(1);
                if (fire) begin
                    next_id_d = next_id_q + ID_W'(1);
                end
                // More completions than could possibly be outstanding:
                // flag it and clamp the credit count instead of wrapping.
                if (AW'(n_done) > avail) begin
                    err_d      = 1'b1;
                    inflight_d = '0;
                end else begin
                    inflight_d = IF_W'(avail - AW'(n_done));
                end
                done_cnt_d = done_sum;
                // Uses the post-update count, so a zero-ray frame leaves
                // after its first RUN cycle.
                if (done_sum >= {1'b0, num_rays_q}) begin
                    state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            num_rays_q <= '0;
            next_id_q  <= '0;
            done_cnt_q <= '0;
            inflight_q <= '0;
            cycles_q   <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            num_rays_q <= num_rays_d;
            next_id_q  <= next_id_d;
            done_cnt_q <= done_cnt_d;
            inflight_q <= inflight_d;
            cycles_q   <= cycles_d;
            err_q      <= err_d;
        end
    end

    assign io_issue_valid    = issue_valid;
    assign io_issue_ray_id   = next_id_q;
    // Lane is forced to 0 while nothing is offered so it is quiet in reset.
    assign io_issue_lane     = issue_valid & grant;
    assign io_busy           = (state_q == RUN);
    assign io_rtp_finish     = (state_q == DONE);
    assign io_inflight       = inflight_q;
    assign io_counter_cycles = cycles_q;
    assign io_err            = err_q;
    assign io_dbg_state      = state_q;

endmodule

// File: tb/tb_rtp_ray_dispatch.sv
module tb_rtp_ray_dispatch;

    localparam int MAXI = 16;
    localparam int ID_W = 32;
    localparam int IF_W = $clog2(MAXI + 1);

    // ---------------- clock / reset / DUT ----------------
    logic            clock;
    logic            reset_n;
    logic            io_start;
    logic [ID_W-1:0] io_num_rays;
    logic            io_issue_valid;
    logic [ID_W-1:0] io_issue_ray_id;
    logic [1:0]      io_issue_ready;
    logic            io_issue_lane;
    logic [1:0]      io_done_valid;
    logic            io_busy;
    logic            io_rtp_finish;
    logic [IF_W-1:0] io_inflight;
    logic [63:0]     io_counter_cycles;
    logic            io_err;
    logic [1:0]      io_dbg_state;

    rtp_ray_dispatch #(.MAX_INFLIGHT(MAXI), .ID_W(ID_W)) dut (
        .clock             (clock),
        .reset_n           (reset_n),
        .io_start          (io_start),
        .io_num_rays       (io_num_rays),
        .io_issue_valid    (io_issue_valid),
        .io_issue_ray_id   (io_issue_ray_id),
        .io_issue_ready    (io_issue_ready),
        .io_issue_lane     (io_issue_lane),
        .io_done_valid     (io_done_valid),
        .io_busy           (io_busy),
        .io_rtp_finish     (io_rtp_finish),
        .io_inflight       (io_inflight),
        .io_counter_cycles (io_counter_cycles),
        .io_err            (io_err),
        .io_dbg_state      (io_dbg_state)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: bench still running at %0t, want finished", $time);
        $fatal(1, "global time limit expired");
    end

    // ---------------- scoreboard state ----------------
    int n_cmp = 0;
    int n_bad = 0;
    logic [ID_W:0] exp_q[$];   // {lane, ray_id} of each expected issue
    bit armed = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, want %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic fail(input string name, input string what);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: %s (t=%0t)", name, what, $time);
    endtask

    // ---------------- reference model (frame-level rules) ----------------
    int     m_phase;          // 0 idle, 1 running, 2 finished
    int     m_nrays, m_next, m_infl, m_dcnt, m_last;
    bit     m_err;
    longint m_cyc;
    // expected outputs for the current cycle
    logic   e_busy, e_fin, e_valid, e_err;
    int     e_infl, e_id;
    longint e_cyc;

    task automatic model_reset();
        m_phase = 0; m_nrays = 0; m_next = 0; m_infl = 0; m_dcnt = 0;
        m_last = 1; m_err = 0; m_cyc = 0;
    endtask

    // ---------------- stimulus controls ----------------
    logic [1:0] s_rdy = 2'b00;
    logic [1:0] s_force = 2'b00;
    bit  s_start = 0, s_hold = 0, s_rst = 1, s_rand_start = 0;
    int  s_nrays = 0, s_lat_min = 1, s_lat_max = 1;
    int  now = 0;
    int  due_q0[$], due_q1[$];   // cycle at which each lane's ray completes

    // One clock cycle: drive inputs at the falling edge, record what the DUT
    // must show this cycle, then advance the model past the next rising edge.
    task automatic step();
        logic [1:0] dn;
        bit st;
        int lane, c, avail, lat;
        bit fire;
        @(negedge clock);
        now++;
        dn = s_force;
        if (!s_hold) begin
            if (due_q0.size() > 0 && due_q0[0] <= now) begin void'(due_q0.pop_front()); dn[0] = 1'b1; end
            if (due_q1.size() > 0 && due_q1[0] <= now) begin void'(due_q1.pop_front()); dn[1] = 1'b1; end
        end
        st = s_start;
        if (s_rand_start && m_phase == 1 && $urandom_range(0, 15) == 0) st = 1;
        if (s_rst) begin
            reset_n = 1'b0;
            model_reset();
        end else begin
            reset_n = 1'b1;
        end
        io_start       = st;
        io_num_rays    = ID_W'(s_nrays);
        io_issue_ready = s_rdy;
        io_done_valid  = dn;

        e_busy  = (m_phase == 1);
        e_fin   = (m_phase == 2);
        e_valid = e_busy && (m_next < m_nrays) && (m_infl < MAXI);
        e_infl  = m_infl;
        e_cyc   = m_cyc;
        e_err   = m_err;
        e_id    = m_next;
        armed   = 1;

        if (s_rst) return;
        if (m_phase != 1) begin
            if (st) begin
                m_phase = 1; m_nrays = s_nrays; m_next = 0; m_infl = 0;
                m_dcnt = 0; m_cyc = 0; m_err = 0;
            end
        end else begin
            m_cyc++;
            fire = e_valid && (s_rdy != 2'b00);
            if (fire) begin
                if (s_rdy == 2'b01)      lane = 0;
                else if (s_rdy == 2'b10) lane = 1;
                else                     lane = 1 - m_last;
                exp_q.push_back({lane[0], m_next[ID_W-1:0]});
                lat = $urandom_range(s_lat_min, s_lat_max);
                if (lane == 0) due_q0.push_back(now + lat);
                else           due_q1.push_back(now + lat);
                m_last = lane;
                m_next++;
            end
            c = int'(dn[0]) + int'(dn[1]);
            avail = m_infl + int'(fire);
            if (c > avail) begin
                m_err = 1;
                m_infl = 0;
            end else begin
                m_infl = avail - c;
            end
            m_dcnt += c;
            if (m_dcnt >= m_nrays) m_phase = 2;
        end
    endtask

    // ---------------- monitor ----------------
    initial begin
        logic [ID_W:0] rec;
        forever begin
            @(negedge clock);
            #2;
            if (armed) begin
                chk("busy", io_busy, e_busy);
                chk("finish", io_rtp_finish, e_fin);
                chk("issue_valid", io_issue_valid, e_valid);
                chk("ray_id_offered", io_issue_ray_id, e_id);
                chk("inflight", io_inflight, e_infl);
                chk("counter_cycles", io_counter_cycles, e_cyc);
                chk("err", io_err, e_err);
                if (io_issue_valid && io_issue_ready != 2'b00) begin
                    if (exp_q.size() == 0) begin
                        fail("issue_unexpected", $sformatf("DUT issued ray %0d, none expected", io_issue_ray_id));
                    end else begin
                        rec = exp_q.pop_front();
                        chk("issue_ray_id", io_issue_ray_id, rec[ID_W-1:0]);
                        chk("issue_lane", io_issue_lane, rec[ID_W]);
                    end
                end
            end
        end
    end

    // ---------------- helpers ----------------
    task automatic wait_finish(input string name, input int budget, input bit rand_rdy);
        bit seen;
        seen = 0;
        for (int i = 0; i < budget; i++) begin
            if (rand_rdy) s_rdy = 2'($urandom_range(0, 3));
            step();
            #1;
            if (io_rtp_finish) begin
                seen = 1;
                break;
            end
        end
        if (!seen) fail(name, $sformatf("finish not seen within %0d cycles", budget));
    endtask

    task automatic start_frame(input int n);
        s_nrays = n;
        s_start = 1;
        step();
        s_start = 0;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_valid"}, io_issue_valid, 0);
        chk({tag, "_ray_id"}, io_issue_ray_id, 0);
        chk({tag, "_lane"}, io_issue_lane, 0);
        chk({tag, "_busy"}, io_busy, 0);
        chk({tag, "_finish"}, io_rtp_finish, 0);
        chk({tag, "_inflight"}, io_inflight, 0);
        chk({tag, "_cycles"}, io_counter_cycles, 0);
        chk({tag, "_err"}, io_err, 0);
    endtask

    // ---------------- test sequence ----------------
    initial begin
        reset_n = 1'b0; io_start = 1'b0; io_num_rays = '0;
        io_issue_ready = 2'b00; io_done_valid = 2'b00;
        model_reset();

        // Reset state (lane 1 alone ready must not leak onto io_issue_lane)
        s_rdy = 2'b10;
        s_rst = 1;
        repeat (3) step();
        #1;
        chk_reset_outputs("reset");
        s_rst = 0;
        step();

        // 8 rays, both lanes ready, completion latency 5 -> 13 RUN cycles
        s_rdy = 2'b11; s_lat_min = 5; s_lat_max = 5;
        start_frame(8);
        wait_finish("finish_n8", 60, 0);
        chk("cycles_n8_l5", io_counter_cycles, 13);

        // Lane 1 alone for three grants, then lane 0 takes the first tie
        s_rdy = 2'b10; s_lat_min = 3; s_lat_max = 6;
        start_frame(20);
        for (int i = 0; i < 3; i++) begin
            step();
            #1;
            chk("lane1_only_valid", io_issue_valid, 1);
            chk("lane1_only_grant", io_issue_lane, 1);
        end
        s_rdy = 2'b11;
        step();
        #1;
        chk("first_tie_grant", io_issue_lane, 0);
        wait_finish("finish_rr", 200, 1);

        // Credit limit: withheld completions stop issue at MAXI rays
        s_rdy = 2'b11; s_hold = 1; s_lat_min = 1; s_lat_max = 3;
        start_frame(40);
        repeat (20) step();
        #1;
        chk("credit_inflight", io_inflight, MAXI);
        chk("credit_valid_low", io_issue_valid, 0);
        chk("credit_next_id", io_issue_ray_id, MAXI);
        void'(due_q0.pop_front());
        s_force = 2'b01;
        step();
        #1;
        chk("credit_no_bypass", io_issue_valid, 0);
        s_force = 2'b00;
        step();
        #1;
        chk("credit_restored_valid", io_issue_valid, 1);
        chk("credit_restored_id", io_issue_ray_id, MAXI);
        s_hold = 0;
        wait_finish("finish_credit", 300, 0);

        // Both lanes complete every cycle: 10 rays retire in 5 cycles
        s_rdy = 2'b00;
        start_frame(10);
        s_force = 2'b11;
        wait_finish("finish_double_done", 20, 0);
        s_force = 2'b00;
        chk("double_done_cycles", io_counter_cycles, 5);
        chk("double_done_err", io_err, 1);

        // Zero-ray frame: one RUN cycle, nothing offered
        s_rdy = 2'b11;
        start_frame(0);
        wait_finish("finish_zero", 5, 0);
        chk("zero_rays_cycles", io_counter_cycles, 1);

        // Start during RUN of a 100-ray frame is ignored
        s_lat_min = 4; s_lat_max = 4;
        start_frame(100);
        repeat (5) step();
        s_nrays = 3; s_start = 1;
        step();
        s_start = 0; s_nrays = 100;
        wait_finish("finish_start_in_run", 300, 0);
        chk("start_in_run_cycles", io_counter_cycles, 104);

        // Completion underflow, then asynchronous reset mid-frame
        s_rdy = 2'b00;
        start_frame(50);
        step();
        s_force = 2'b01;
        step();
        s_force = 2'b00;
        step();
        #1;
        chk("underflow_err", io_err, 1);
        chk("underflow_inflight", io_inflight, 0);
        s_rdy = 2'b11; s_lat_min = 3; s_lat_max = 8;
        repeat (8) step();
        @(posedge clock);
        #3;
        reset_n = 1'b0;
        s_rst = 1;
        model_reset();
        #1;
        chk_reset_outputs("async_reset");
        repeat (2) step();
        s_rst = 0;
        for (int i = 0; i < 12; i++) begin
            s_rdy = 2'($urandom_range(0, 3));
            step();
        end
        s_rdy = 2'b11;
        start_frame(5);
        step();
        #1;
        chk("after_reset_valid", io_issue_valid, 1);
        chk("after_reset_first_id", io_issue_ray_id, 0);
        wait_finish("finish_after_reset", 100, 0);

        // Randomized frames: random ready, latency and stray starts in RUN
        for (int f = 0; f < 6; f++) begin
            s_lat_min = $urandom_range(1, 4);
            s_lat_max = s_lat_min + $urandom_range(0, 6);
            s_rand_start = 1;
            start_frame($urandom_range(1, 60));
            wait_finish("finish_random", 2000, 1);
            s_rand_start = 0;
        end

        s_rdy = 2'b00;
        repeat (5) step();
        chk("issue_queue_drained", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
